// File: rtl/ow_pkg.sv
// Shared 1-Wire slot definitions: command encodings, FSM states and standard-speed
// slot timing in microseconds.
package ow_pkg;

  typedef enum logic [1:0] {
    OW_CMD_WRITE = 2'b00,
    OW_CMD_READ  = 2'b01,
    OW_CMD_RESET = 2'b10,
    OW_CMD_RSVD  = 2'b11
  } ow_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_RELEASE,
    ST_RECOVER,
    ST_DONE
  } ow_state_e;

  localparam int US_W = 10;

  localparam logic [US_W-1:0] T_W0_LOW    = 10'd60;
  localparam logic [US_W-1:0] T_W1_LOW    = 10'd6;
  localparam logic [US_W-1:0] T_SAMPLE    = 10'd15;
  localparam logic [US_W-1:0] T_SLOT      = 10'd60;
  localparam logic [US_W-1:0] T_REC       = 10'd65;
  localparam logic [US_W-1:0] T_RST_LOW   = 10'd480;
  localparam logic [US_W-1:0] T_PD_SAMPLE = 10'd550;
  localparam logic [US_W-1:0] T_RST_END   = 10'd960;

  typedef struct packed {
    logic [US_W-1:0] t_low;
    logic [US_W-1:0] t_sample;
    logic [US_W-1:0] t_slot;
    logic [US_W-1:0] t_end;
  } ow_timing_t;

  // A reset pulse has no separate recovery window: the slot and the command end together.
  function automatic ow_timing_t ow_timing(input ow_cmd_e c, input logic wbit);
    ow_timing_t t;
    t.t_low    = (c == OW_CMD_WRITE && !wbit) ? T_W0_LOW : T_W1_LOW;
    t.t_sample = T_SAMPLE;
    t.t_slot   = T_SLOT;
    t.t_end    = T_REC;
    if (c == OW_CMD_RESET) begin
      t.t_low    = T_RST_LOW;
      t.t_sample = T_PD_SAMPLE;
      t.t_slot   = T_RST_END;
      t.t_end    = T_RST_END;
    end
    return t;
  endfunction

endpackage

// File: rtl/ow_bus_sync.sv
// 2-FF synchroniser for the raw 1-Wire bus level, with an optional glitch filter
// enabled by OW_GLITCH_FILTER_EN. The output idles high (released bus).
module ow_bus_sync #(
  parameter int GLITCH_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic bus_in,
  output logic bus_s
);

  if (GLITCH_CYC < 1) begin : g_bad_glitch_cyc
    $error("GLITCH_CYC must be at least 1");
  end

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], bus_in};
  end

`ifdef OW_GLITCH_FILTER_EN
  localparam int CW = $clog2(GLITCH_CYC + 1);

  logic [CW-1:0] run_cnt;
  logic          filt_q;

  // A new level wins only after GLITCH_CYC consecutive samples disagree with the held one.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt <= '0;
      filt_q  <= 1'b1;
    end else if (sync_q[1] == filt_q) begin
      run_cnt <= '0;
    end else if (run_cnt == CW'(GLITCH_CYC - 1)) begin
      run_cnt <= '0;
      filt_q  <= sync_q[1];
    end else begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

  assign bus_s = filt_q;
`else
  assign bus_s = sync_q[1];
`endif

endmodule

// File: rtl/ow_slot_engine.sv
// 1-Wire standard-speed slot generator: one WRITE/READ/RESET command in, one result out.
// Optional bus glitch filtering is enabled by defining OW_GLITCH_FILTER_EN.
//
// state      | meaning
// IDLE       | ready for a command, bus released
// LOW        | driving the bus low for t_low
// RELEASE    | bus released, waiting for slot end (sample may land here)
// RECOVER    | inter-slot recovery up to t_end
// DONE       | one-cycle result pulse
module ow_slot_engine
  import ow_pkg::*;
#(
  parameter int TICKS_PER_US = 50,
  parameter int GLITCH_CYC   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic       cmd_bit,
  output logic       rsp_valid,
  output logic       rsp_bit,
  output logic       rsp_err,
  input  logic       bus_in,
  output logic       bus_drive_low,
  output logic       busy
);

  localparam int PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam logic [PW-1:0] PRE_TC = PW'(TICKS_PER_US - 1);

  ow_state_e       state, state_nxt;
  ow_cmd_e         cmd_q;
  logic            bit_q;
  logic [PW-1:0]   pre_cnt;
  logic [US_W-1:0] us_cnt, us_next;
  logic            samp_q, rsp_bit_q, rsp_err_q;
  logic            bus_s, accept, active, tick;
  ow_timing_t      tm;

  ow_bus_sync #(.GLITCH_CYC(GLITCH_CYC)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .bus_in (bus_in),
    .bus_s  (bus_s)
  );

  assign tm      = ow_timing(cmd_q, bit_q);
  assign accept  = cmd_valid && (state == ST_IDLE);
  assign active  = (state == ST_LOW) || (state == ST_RELEASE) || (state == ST_RECOVER);
  assign tick    = active && (pre_cnt == PRE_TC);
  assign us_next = (us_cnt == T_RST_END) ? us_cnt : us_cnt + 10'd1;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Timing events fire on the tick edge where us_cnt reaches the target.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (accept) begin
          if (ow_cmd_e'(cmd) == OW_CMD_RSVD || !bus_s) state_nxt = ST_DONE;
          else                                         state_nxt = ST_LOW;
        end
      ST_LOW:
        if (tick && us_next == tm.t_low)
          state_nxt = (us_next >= tm.t_slot) ? ST_RECOVER : ST_RELEASE;
      ST_RELEASE:
        if (tick && us_next == tm.t_slot)
          state_nxt = (us_next >= tm.t_end) ? ST_DONE : ST_RECOVER;
      ST_RECOVER:
        if (tick && us_next == tm.t_end) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready     = (state == ST_IDLE);
    busy          = (state != ST_IDLE);
    rsp_valid     = (state == ST_DONE);
    bus_drive_low = (state == ST_LOW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q     <= OW_CMD_WRITE;
      bit_q     <= 1'b0;
      pre_cnt   <= '0;
      us_cnt    <= '0;
      samp_q    <= 1'b0;
      rsp_bit_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      if (accept) begin
        cmd_q   <= ow_cmd_e'(cmd);
        bit_q   <= cmd_bit;
        pre_cnt <= '0;
        us_cnt  <= '0;
      end else if (active) begin
        if (tick) begin
          pre_cnt <= '0;
          us_cnt  <= us_next;
        end else begin
          pre_cnt <= pre_cnt + 1'b1;
        end
      end

      if ((state == ST_LOW || state == ST_RELEASE) && tick && us_next == tm.t_sample)
        samp_q <= bus_s;

      // Results are written on entry to DONE so they change together with rsp_valid.
      if (state != ST_DONE && state_nxt == ST_DONE) begin
        if (state == ST_IDLE) begin
          rsp_bit_q <= 1'b0;
          rsp_err_q <= 1'b1;
        end else if (cmd_q == OW_CMD_RESET) begin
          rsp_bit_q <= ~samp_q;
          rsp_err_q <= ~bus_s;
        end else begin
          rsp_bit_q <= samp_q;
          rsp_err_q <= 1'b0;
        end
      end
    end
  end

  assign rsp_bit = rsp_bit_q;
  assign rsp_err = rsp_err_q;

endmodule

// File: tb/tb_ow_slot_engine.sv
// Directed bench for ow_slot_engine: scoreboard queue filled by stimulus, drained by a
// monitor on every rsp_valid. Bus is open-drain: DUT drive, slave model or a forced short.
module tb_ow_slot_engine;

  localparam int TPU = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd = 2'b00;
  logic       cmd_bit = 1'b0;
  logic       rsp_valid, rsp_bit, rsp_err;
  logic       bus_in, bus_drive_low, busy;

  int  cyc = 0;
  int  acc_cyc = 0;
  logic win_en = 1'b0;
  int  win_lo = 0, win_hi = 0;
  logic force_low = 1'b0;
  logic slave_low;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic b;
    logic e;
    int   drive;
    int   gap;
  } exp_t;
  exp_t exp_q[$];

  int   drive_cnt = 0;
  int   last_rsp_cyc = 0;
  int   rsp_cnt = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign slave_low = win_en && ((cyc - acc_cyc) >= win_lo) && ((cyc - acc_cyc) < win_hi);
  assign bus_in    = !(bus_drive_low || slave_low || force_low);

  ow_slot_engine #(.TICKS_PER_US(TPU), .GLITCH_CYC(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd           (cmd),
    .cmd_bit       (cmd_bit),
    .rsp_valid     (rsp_valid),
    .rsp_bit       (rsp_bit),
    .rsp_err       (rsp_err),
    .bus_in        (bus_in),
    .bus_drive_low (bus_drive_low),
    .busy          (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per rsp_valid pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      drive_cnt  = 0;
      prev_valid = 1'b0;
    end else begin
      if (bus_drive_low) drive_cnt++;
      if (rsp_valid) begin
        rsp_cnt++;
        chk("rsp_pulse_width", prev_valid, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_bit", rsp_bit, e.b);
          chk("rsp_err", rsp_err, e.e);
          chk("drive_low_cycles", drive_cnt, e.drive);
          if (e.gap > 0) chk("rsp_spacing", cyc - last_rsp_cyc, e.gap);
        end
        drive_cnt    = 0;
        last_rsp_cyc = cyc;
      end
      prev_valid = rsp_valid;
    end
  end

  task automatic issue(input logic [1:0] c, input logic b, input logic push,
                       input logic eb, input logic ee, input int edrive);
    exp_t e;
    if (push) begin
      e.b = eb; e.e = ee; e.drive = edrive; e.gap = 0;
      exp_q.push_back(e);
    end
    @(negedge clk);
    cmd = c; cmd_bit = b; cmd_valid = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (cmd_ready) begin
        @(posedge clk);
        acc_cyc = cyc;
        #1 cmd_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_done(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    chk("done_timeout", (i < limit) ? 1 : 0, 1);
    win_en = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic set_win(input int lo_us, input int hi_us);
    win_lo = lo_us * TPU;
    win_hi = hi_us * TPU;
    win_en = 1'b1;
  endtask

  initial begin
    int n;
    int base;
    exp_t e;

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_bit", rsp_bit, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_drive_low", bus_drive_low, 0);
    chk("reset_busy", busy, 0);

    // Write slots and reads with/without a slave pulling low over the sample point
    issue(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 60 * TPU);
    wait_done(2000);
    issue(2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 6 * TPU);
    wait_done(2000);
    set_win(6, 30);
    issue(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 6 * TPU);
    wait_done(2000);
    issue(2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 6 * TPU);
    wait_done(2000);

    // Reset/presence: present, absent, bus still held low at the end
    set_win(540, 600);
    issue(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 480 * TPU);
    wait_done(8000);
    issue(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 480 * TPU);
    wait_done(8000);
    set_win(900, 962);
    issue(2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 480 * TPU);
    wait_done(8000);

    // Reserved command and a shorted bus
    issue(2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 0);
    @(negedge clk);
    chk("rsvd_rsp_next_cycle", rsp_valid, 1);
    wait_done(100);
    force_low = 1'b1;
    repeat (5) @(negedge clk);
    issue(2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 0);
    wait_done(100);
    force_low = 1'b0;
    repeat (5) @(negedge clk);

    // Reset in the middle of a reset pulse drops the command
    issue(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    repeat (100 * TPU) @(negedge clk);
    chk("drive_low_before_rst", bus_drive_low, 1);
    n = rsp_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("drive_low_after_rst", bus_drive_low, 0);
    chk("busy_after_rst", busy, 0);
    rst = 1'b0;
    repeat (1000 * TPU) @(negedge clk);
    chk("no_rsp_after_rst", rsp_cnt - n, 0);
    issue(2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 6 * TPU);
    wait_done(2000);

    // Back-to-back reads with cmd_valid held high
    for (int k = 0; k < 3; k++) begin
      e.b = 1'b1; e.e = 1'b0; e.drive = 6 * TPU; e.gap = (k == 0) ? 0 : 65 * TPU + 2;
      exp_q.push_back(e);
    end
    @(negedge clk);
    cmd = 2'b01; cmd_bit = 1'b0; cmd_valid = 1'b1;
    n = 0;
    base = 0;
    for (int i = 0; i < 2000 && n < 3; i++) begin
      if (i == 100) chk("ready_low_while_busy", cmd_ready, 0);
      if (cmd_ready) n++;
      if (n < 3) @(negedge clk);
      base = i;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    chk("b2b_accepts", n, 3);
    wait_done(2000);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
